p4_router_egress_demux: RTL and testbench



---
 rtl/p4_router_pkg.sv | 25 ++
 rtl/axis_int.sv | 24 ++
 rtl/p4_router_meta_fifo.sv | 53 +++++
 rtl/p4_router_egress_demux.sv | 186 ++++++++++++++++++
 tb/tb_p4_router_egress_demux.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p4_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : p4_router_pkg
// Brief    : Shared types and constants for the P4 router egress demux.
// Revision : 1.0
// ============================================================================
package p4_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_e;

    localparam logic [7:0] EGR_ID_INVALID  = 8'hFF;
    localparam int         META_EGR_SPEC_W = 8;
    localparam int         META_ING_PORT_W = 8;

    typedef struct packed {
        logic [META_EGR_SPEC_W-1:0] egr_spec;
        logic [META_ING_PORT_W-1:0] ing_port;
    } meta_t;

endpackage
`default_nettype wire

// File: rtl/axis_int.sv
`default_nettype none
// ============================================================================
// Module   : AXIS_int
// Brief    : AXI4-Stream interface bundle with master/slave modports.
// Revision : 1.0
// ============================================================================
interface AXIS_int #(
    parameter int DATA_BYTES = 8
) (
    input logic clk,
    input logic sresetn
);
    logic                      tvalid;
    logic                      tready;
    logic [8*DATA_BYTES-1:0]   tdata;
    logic [DATA_BYTES-1:0]     tkeep;
    logic                      tlast;

    modport Master (input clk, input sresetn, input tready,
                    output tvalid, output tdata, output tkeep, output tlast);
    modport Slave  (input clk, input sresetn, output tready,
                    input tvalid, input tdata, input tkeep, input tlast);
endinterface
`default_nettype wire

// File: rtl/p4_router_meta_fifo.sv
`default_nettype none
// ============================================================================
// Module   : p4_router_meta_fifo
// Brief    : Synchronous FIFO, async active-low reset, registered-pointer read.
// Revision : 1.0
// ============================================================================
module p4_router_meta_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/p4_router_egress_demux.sv
`default_nettype none
// ============================================================================
// Module   : p4_router_egress_demux
// Brief    : Steers whole VNP4 packets to one of NUM_EGR_PORTS AXIS streams
//            using buffered metadata. Counters: P4_ROUTER_EGRESS_DEMUX_STATS_EN.
// Revision : 1.0
// ============================================================================
module p4_router_egress_demux
    import p4_router_pkg::*;
#(
    parameter int NUM_EGR_PORTS     = 11,
    parameter int EGR_SPEC_ID_WIDTH = 8,
    parameter int ING_PORT_ID_WIDTH = 8,
    parameter int DATA_BYTES        = 8,
    parameter int META_FIFO_DEPTH   = 4,
    parameter int STATS_WIDTH       = 32
) (
    input  logic                         clk,
    input  logic                         aresetn,
    AXIS_int.Slave                       packet_data_in,
    input  logic [EGR_SPEC_ID_WIDTH-1:0] user_metadata_in_egr_spec,
    input  logic [ING_PORT_ID_WIDTH-1:0] user_metadata_in_ing_port,
    input  logic                         user_metadata_in_valid,
    AXIS_int.Master                      packet_data_out [NUM_EGR_PORTS],
    output logic [ING_PORT_ID_WIDTH-1:0] egr_ing_port,
    output logic                         meta_overflow,
    output logic [STATS_WIDTH-1:0]       drop_count,
    output logic [STATS_WIDTH-1:0]       egr_pkt_count [NUM_EGR_PORTS]
);
    localparam int SEL_W = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1;

    if (NUM_EGR_PORTS < 1) begin : g_chk_num_ports
        $error("NUM_EGR_PORTS must be at least 1");
    end
    if (EGR_SPEC_ID_WIDTH < $clog2(NUM_EGR_PORTS + 1) ||
        EGR_SPEC_ID_WIDTH > META_EGR_SPEC_W) begin : g_chk_spec_w
        $error("EGR_SPEC_ID_WIDTH out of range");
    end
    if (ING_PORT_ID_WIDTH > META_ING_PORT_W) begin : g_chk_ing_w
        $error("ING_PORT_ID_WIDTH exceeds metadata field width");
    end
    if (META_FIFO_DEPTH < 2 ||
        (META_FIFO_DEPTH & (META_FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("META_FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (packet_data_in.DATA_BYTES != DATA_BYTES) begin : g_chk_in_bytes
        $error("packet_data_in DATA_BYTES mismatch");
    end

    state_e                         state_q, state_d;
    logic [SEL_W-1:0]               sel_q, sel_d;
    logic [ING_PORT_ID_WIDTH-1:0]   ing_q, ing_d;
    logic                           ovf_q;
    meta_t                          meta_wr, meta_rd;
    logic                           w_full, w_empty, w_pop;
    logic                           w_spec_valid;
    logic                           w_in_tready;
    logic [NUM_EGR_PORTS-1:0]       w_out_tready;
    logic                           w_fwd_done, w_drop_done;

    always_comb begin
        meta_wr          = '0;
        meta_wr.egr_spec = META_EGR_SPEC_W'(user_metadata_in_egr_spec);
        meta_wr.ing_port = META_ING_PORT_W'(user_metadata_in_ing_port);
    end

    p4_router_meta_fifo #(
        .WIDTH ($bits(meta_t)),
        .DEPTH (META_FIFO_DEPTH)
    ) u_meta_fifo (
        .clk   (clk),
        .rst_n (aresetn),
        .push  (user_metadata_in_valid),
        .din   (meta_wr),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (meta_rd),
        .empty (w_empty)
    );

    assign w_spec_valid = (meta_rd.egr_spec != EGR_ID_INVALID) &&
                          (meta_rd.egr_spec < META_EGR_SPEC_W'(NUM_EGR_PORTS));

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ing_d       = ing_q;
        w_pop       = 1'b0;
        w_in_tready = 1'b0;
        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    sel_d   = meta_rd.egr_spec[SEL_W-1:0];
                    ing_d   = meta_rd.ing_port[ING_PORT_ID_WIDTH-1:0];
                    state_d = w_spec_valid ? FWD : DROP;
                end
            end
            FWD: begin
                w_in_tready = w_out_tready[sel_q];
                if (packet_data_in.tvalid && w_in_tready && packet_data_in.tlast) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                w_in_tready = 1'b1;
                if (packet_data_in.tvalid && packet_data_in.tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ing_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ing_q   <= ing_d;
            if (user_metadata_in_valid && w_full) ovf_q <= 1'b1;
        end
    end

    assign packet_data_in.tready = w_in_tready;
    assign egr_ing_port          = ing_q;
    assign meta_overflow         = ovf_q;
    assign w_fwd_done  = (state_q == FWD) && packet_data_in.tvalid &&
                         w_in_tready && packet_data_in.tlast;
    assign w_drop_done = (state_q == DROP) && packet_data_in.tvalid &&
                         packet_data_in.tlast;

    // sel_q only changes in IDLE, so the selected egress never switches mid-packet.
    for (genvar gi = 0; gi < NUM_EGR_PORTS; gi++) begin : g_egr
        logic w_sel;
        logic w_unused_if;
        assign w_sel                       = (state_q == FWD) && (sel_q == SEL_W'(gi));
        assign packet_data_out[gi].tvalid  = w_sel && packet_data_in.tvalid;
        assign packet_data_out[gi].tdata   = packet_data_in.tdata;
        assign packet_data_out[gi].tkeep   = packet_data_in.tkeep;
        assign packet_data_out[gi].tlast   = packet_data_in.tlast;
        assign w_out_tready[gi]            = packet_data_out[gi].tready;
        assign w_unused_if = &{1'b0, packet_data_out[gi].clk, packet_data_out[gi].sresetn};
    end

    logic w_unused_in;
    assign w_unused_in = &{1'b0, packet_data_in.clk, packet_data_in.sresetn};

`ifdef P4_ROUTER_EGRESS_DEMUX_STATS_EN
    logic [STATS_WIDTH-1:0] drop_cnt_q;
    logic [STATS_WIDTH-1:0] pkt_cnt_q [NUM_EGR_PORTS];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt_q <= '0;
        end else if (w_drop_done && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end
    assign drop_count = drop_cnt_q;

    for (genvar gi = 0; gi < NUM_EGR_PORTS; gi++) begin : g_pkt_cnt
        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                pkt_cnt_q[gi] <= '0;
            end else if (w_fwd_done && (sel_q == SEL_W'(gi)) && (pkt_cnt_q[gi] != '1)) begin
                pkt_cnt_q[gi] <= pkt_cnt_q[gi] + 1'b1;
            end
        end
        assign egr_pkt_count[gi] = pkt_cnt_q[gi];
    end
`else
    assign drop_count = '0;
    for (genvar gi = 0; gi < NUM_EGR_PORTS; gi++) begin : g_pkt_cnt_tie
        assign egr_pkt_count[gi] = '0;
    end
    logic w_unused_stats;
    assign w_unused_stats = &{1'b0, w_fwd_done, w_drop_done};
`endif

endmodule
`default_nettype wire

// File: tb/tb_p4_router_egress_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_p4_router_egress_demux
// Brief    : Scoreboard bench for the egress demux (routing, drop, stall, reset).
// Revision : 1.0
// ============================================================================
module tb_p4_router_egress_demux;
    localparam int NP = 11;
    localparam int DB = 8;
    localparam int SW = 32;
`ifdef P4_ROUTER_EGRESS_DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]    m_spec;
    logic [7:0]    m_ing;
    logic          m_valid;
    logic [NP-1:0] o_ready;
    wire  [NP-1:0] o_valid;
    wire  [NP-1:0] o_last;
    wire  [63:0]   o_data [NP];
    wire  [7:0]    o_keep [NP];
    logic [7:0]    egr_ing_port;
    logic          meta_overflow;
    logic [SW-1:0] drop_count;
    logic [SW-1:0] egr_pkt_count [NP];

    AXIS_int #(.DATA_BYTES(DB)) in_if (.clk(clk), .sresetn(aresetn));
    AXIS_int #(.DATA_BYTES(DB)) out_if [NP] (.clk(clk), .sresetn(aresetn));

    for (genvar g = 0; g < NP; g++) begin : g_mon
        assign o_valid[g]      = out_if[g].tvalid;
        assign o_last[g]       = out_if[g].tlast;
        assign o_data[g]       = out_if[g].tdata;
        assign o_keep[g]       = out_if[g].tkeep;
        assign out_if[g].tready = o_ready[g];
    end

    p4_router_egress_demux #(
        .NUM_EGR_PORTS(NP), .EGR_SPEC_ID_WIDTH(8), .ING_PORT_ID_WIDTH(8),
        .DATA_BYTES(DB), .META_FIFO_DEPTH(4), .STATS_WIDTH(SW)
    ) dut (
        .clk                       (clk),
        .aresetn                   (aresetn),
        .packet_data_in            (in_if),
        .user_metadata_in_egr_spec (m_spec),
        .user_metadata_in_ing_port (m_ing),
        .user_metadata_in_valid    (m_valid),
        .packet_data_out           (out_if),
        .egr_ing_port              (egr_ing_port),
        .meta_overflow             (meta_overflow),
        .drop_count                (drop_count),
        .egr_pkt_count             (egr_pkt_count)
    );

    typedef struct {
        int         port;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_pkt [NP];
    int exp_drop = 0;
    int first_out_cyc = -1;

    // Output monitor: every valid beat must belong to the head of the scoreboard.
    always @(negedge clk) begin
        if (aresetn) begin
            for (int p = 0; p < NP; p++) begin
                if (o_valid[p]) begin
                    if (exp_q.size() == 0 || exp_q[0].port != p) begin
                        n_checks++;
                        $display("FAIL unexpected_beat port=%0d data=%h expected_port=%0d",
                                 p, o_data[p], (exp_q.size() == 0) ? -1 : exp_q[0].port);
                    end else if (o_ready[p]) begin
                        beat_t e;
                        e = exp_q.pop_front();
                        n_checks++;
                        if (o_data[p] !== e.data || o_keep[p] !== e.keep || o_last[p] !== e.last) begin
                            $display("FAIL beat port=%0d got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                                     p, o_data[p], o_keep[p], o_last[p], e.data, e.keep, e.last);
                        end else begin
                            n_pass++;
                        end
                        if (first_out_cyc < 0) first_out_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] beat_keep(input logic [63:0] base, input int i);
        return base[7:0] ^ 8'(i);
    endfunction

    task automatic push_exp(input int port, input int len, input logic [63:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.port = port;
            b.data = base + 64'(i);
            b.keep = beat_keep(base, i);
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic meta_push(input logic [7:0] spec, input logic [7:0] ing);
        m_spec  = spec;
        m_ing   = ing;
        m_valid = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [63:0] base,
                            output int first_acc, output int last_acc);
        int t;
        first_acc = -1;
        last_acc  = -1;
        for (int i = 0; i < len; i++) begin
            in_if.tvalid = 1'b1;
            in_if.tdata  = base + 64'(i);
            in_if.tkeep  = beat_keep(base, i);
            in_if.tlast  = (i == len - 1);
            t = 0;
            @(negedge clk);
            while (!in_if.tready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_if.tready) begin
                n_checks++;
                $display("FAIL send_timeout beat=%0d tready=%b required=1", i, in_if.tready);
                in_if.tvalid = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk); #1;
        end
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_valid !== '0) $display("FAIL rst_tvalid got=%b want=0", o_valid);
        else n_pass++;
        n_checks++;
        if (in_if.tready !== 1'b0) $display("FAIL rst_tready got=%b want=0", in_if.tready);
        else n_pass++;
        n_checks++;
        if (egr_ing_port !== 8'h00 || meta_overflow !== 1'b0)
            $display("FAIL rst_regs got ing=%h ovf=%b want ing=00 ovf=0", egr_ing_port, meta_overflow);
        else n_pass++;
        bad = 0;
        for (int p = 0; p < NP; p++) if (egr_pkt_count[p] !== '0) bad++;
        n_checks++;
        if (drop_count !== '0 || bad != 0)
            $display("FAIL rst_counters got drop=%0d nonzero_ports=%0d want 0/0", drop_count, bad);
        else n_pass++;
        aresetn = 1'b1;
        in_if.tvalid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_if.tready !== 1'b0) $display("FAIL rst_release_stall got tready=%b want=0", in_if.tready);
        else n_pass++;
        in_if.tvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fwd();
        int k, fa, la, bad;
        k = cyc;
        first_out_cyc = -1;
        meta_push(8'd3, 8'h37);
        push_exp(3, 4, 64'h1000);
        send_pkt(4, 64'h1000, fa, la);
        exp_pkt[3]++;
        n_checks++;
        if (fa - k != 2) $display("FAIL fwd_latency got=%0d want=2", fa - k);
        else n_pass++;
        n_checks++;
        if (la - fa != 3 || first_out_cyc != fa)
            $display("FAIL fwd_burst got span=%0d out_cyc=%0d want span=3 out_cyc=%0d", la - fa, first_out_cyc, fa);
        else n_pass++;
        n_checks++;
        if (egr_ing_port !== 8'h37) $display("FAIL fwd_ing_port got=%h want=37", egr_ing_port);
        else n_pass++;
        bad = 0;
        for (int p = 0; p < NP; p++)
            if (egr_pkt_count[p] !== SW'(STATS ? exp_pkt[p] : 0)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL fwd_pkt_count got port3=%0d want=%0d bad_ports=%0d",
                               egr_pkt_count[3], STATS ? exp_pkt[3] : 0, bad);
        else n_pass++;
    endtask

    task automatic test_drop();
        int k, fa, la;
        k = cyc;
        meta_push(8'hFF, 8'h11);
        send_pkt(3, 64'h2000, fa, la);
        exp_drop++;
        n_checks++;
        if (fa - k != 2 || la - fa != 2)
            $display("FAIL drop_timing got start=%0d span=%0d want start=2 span=2", fa - k, la - fa);
        else n_pass++;
        n_checks++;
        if (egr_ing_port !== 8'h11) $display("FAIL drop_ing_port got=%h want=11", egr_ing_port);
        else n_pass++;
        // Spec equal to the port count is the first out-of-range value.
        meta_push(8'(NP), 8'h12);
        send_pkt(1, 64'h2100, fa, la);
        exp_drop++;
        n_checks++;
        if (drop_count !== SW'(STATS ? exp_drop : 0) || exp_q.size() != 0)
            $display("FAIL drop_count got=%0d want=%0d pending=%0d", drop_count, STATS ? exp_drop : 0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int fa, la;
        meta_push(8'd5, 8'h25);
        push_exp(5, 6, 64'h3000);
        fork
            send_pkt(6, 64'h3000, fa, la);
            begin
                repeat (4) @(posedge clk);
                #1 o_ready[5] = 1'b0;
                repeat (5) @(posedge clk);
                @(negedge clk);
                n_checks++;
                if (in_if.tready !== 1'b0 || in_if.tvalid !== 1'b1)
                    $display("FAIL stall_tready got tready=%b tvalid=%b want 0/1", in_if.tready, in_if.tvalid);
                else n_pass++;
                repeat (5) @(posedge clk);
                #1 o_ready[5] = 1'b1;
            end
        join
        exp_pkt[5]++;
        n_checks++;
        if (la - fa != 15) $display("FAIL stall_span got=%0d want=15", la - fa);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] specs [6];
        int fa, la, stall_bad;
        specs = '{8'd1, 8'd2, 8'd4, 8'd10, 8'd9, 8'd7};
        // The first spec is popped into the FSM at once, so six pulses fill a depth-4 FIFO.
        for (int i = 0; i < 5; i++) meta_push(specs[i], 8'(8'h60 + i));
        n_checks++;
        if (meta_overflow !== 1'b0) $display("FAIL ovf_early got=%b want=0", meta_overflow);
        else n_pass++;
        meta_push(specs[5], 8'h65);
        n_checks++;
        if (meta_overflow !== 1'b1) $display("FAIL ovf_set got=%b want=1", meta_overflow);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            push_exp(int'(specs[i]), 2, 64'h4000 + 64'(i * 16));
            send_pkt(2, 64'h4000 + 64'(i * 16), fa, la);
            exp_pkt[specs[i]]++;
        end
        n_checks++;
        if (egr_ing_port !== 8'h64) $display("FAIL ovf_last_ing got=%h want=64", egr_ing_port);
        else n_pass++;
        in_if.tvalid = 1'b1;
        in_if.tdata  = 64'h5000;
        in_if.tkeep  = beat_keep(64'h5000, 0);
        in_if.tlast  = 1'b1;
        stall_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_if.tready !== 1'b0) stall_bad++;
        end
        n_checks++;
        if (stall_bad != 0) $display("FAIL ovf_lost_spec got ready_cycles=%0d want=0", stall_bad);
        else n_pass++;
        @(posedge clk); #1;
        meta_push(8'd0, 8'h44);
        push_exp(0, 1, 64'h5000);
        send_pkt(1, 64'h5000, fa, la);
        exp_pkt[0]++;
        n_checks++;
        if (meta_overflow !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", meta_overflow);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int la, bad;
        for (int i = 0; i < 3; i++) meta_push(8'(i), 8'(8'h70 + i));
        for (int i = 0; i < 3; i++) push_exp(i, 1, 64'h6000 + 64'(i));
        for (int i = 0; i < 3; i++) begin
            send_pkt(1, 64'h6000 + 64'(i), acc[i], la);
            exp_pkt[i]++;
        end
        n_checks++;
        if (acc[1] - acc[0] != 2 || acc[2] - acc[1] != 2)
            $display("FAIL b2b_spacing got=%0d,%0d want=2,2", acc[1] - acc[0], acc[2] - acc[1]);
        else n_pass++;
        bad = 0;
        for (int p = 0; p < NP; p++)
            if (egr_pkt_count[p] !== SW'(STATS ? exp_pkt[p] : 0)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL b2b_pkt_count got bad_ports=%0d port0=%0d want=%0d",
                               bad, egr_pkt_count[0], STATS ? exp_pkt[0] : 0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int t, bad, k, fa, la;
        meta_push(8'd2, 8'h55);
        push_exp(2, 4, 64'h7000);
        in_if.tvalid = 1'b1;
        in_if.tdata  = 64'h7000;
        in_if.tkeep  = beat_keep(64'h7000, 0);
        in_if.tlast  = 1'b0;
        t = 0;
        @(negedge clk);
        while (!o_valid[2] && t < 20) begin @(negedge clk); t++; end
        n_checks++;
        if (!o_valid[2]) $display("FAIL arst_start got valid2=%b want=1", o_valid[2]);
        else n_pass++;
        @(posedge clk); #1;
        in_if.tdata = 64'h7001;
        in_if.tkeep = beat_keep(64'h7000, 1);
        @(negedge clk);
        #2 aresetn = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== '0 || in_if.tready !== 1'b0)
            $display("FAIL arst_outputs got valid=%b tready=%b want 0/0", o_valid, in_if.tready);
        else n_pass++;
        bad = 0;
        for (int p = 0; p < NP; p++) if (egr_pkt_count[p] !== '0) bad++;
        n_checks++;
        if (egr_ing_port !== 8'h00 || meta_overflow !== 1'b0 || drop_count !== '0 || bad != 0)
            $display("FAIL arst_regs got ing=%h ovf=%b drop=%0d bad_ports=%0d want 00/0/0/0",
                     egr_ing_port, meta_overflow, drop_count, bad);
        else n_pass++;
        exp_q.delete();
        for (int p = 0; p < NP; p++) exp_pkt[p] = 0;
        exp_drop = 0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (in_if.tready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL arst_idle got ready_cycles=%0d want=0", bad);
        else n_pass++;
        in_if.tvalid = 1'b0;
        @(posedge clk); #1;
        k = cyc;
        meta_push(8'd4, 8'h56);
        push_exp(4, 2, 64'h7100);
        send_pkt(2, 64'h7100, fa, la);
        exp_pkt[4]++;
        n_checks++;
        if (fa - k != 2 || egr_pkt_count[4] !== SW'(STATS ? exp_pkt[4] : 0) || egr_pkt_count[2] !== '0)
            $display("FAIL arst_recover got lat=%0d cnt4=%0d cnt2=%0d want 2/%0d/0",
                     fa - k, egr_pkt_count[4], egr_pkt_count[2], STATS ? exp_pkt[4] : 0);
        else n_pass++;
    endtask

    initial begin
        m_spec = '0;
        m_ing = '0;
        m_valid = 1'b0;
        o_ready = '1;
        in_if.tvalid = 1'b0;
        in_if.tdata = '0;
        in_if.tkeep = '0;
        in_if.tlast = 1'b0;
        for (int p = 0; p < NP; p++) exp_pkt[p] = 0;
        #1;
        test_reset();
        test_fwd();
        test_drop();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain got pending=%0d want=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
